// File: rtl/dac_stream_scheduler.sv
// Round-robin scheduler merging two sample streams into one gap-free DAC stream,
// with an IQ reset/sync pulse at start-up and hold-last-sample on underflow.
//
// state | meaning
// IDLE  | stopped; DAC held in IQ reset, no stream output
// SYNC  | DAC IQ reset pulse, lasts INT_IQRST_CYCLES cycles
// RUN   | streaming; one sample presented to the DAC every cycle
module dac_stream_scheduler #(
    parameter int INT_AXIS_DATA_WIDTH = 32,
    parameter int INT_BURST_LEN       = 16,
    parameter int INT_IQRST_CYCLES    = 4
) (
    input  logic                           aclk,
    input  logic                           in_rst,
    input  logic                           in_enable,
    input  logic                           s0_axis_valid,
    input  logic [INT_AXIS_DATA_WIDTH-1:0] s0_axis_data,
    output logic                           s0_axis_ready,
    input  logic                           s1_axis_valid,
    input  logic [INT_AXIS_DATA_WIDTH-1:0] s1_axis_data,
    output logic                           s1_axis_ready,
    output logic                           m_axis_valid,
    output logic [INT_AXIS_DATA_WIDTH-1:0] m_axis_data,
    output logic                           out_dac_rst,
    output logic                           out_grant,
    output logic [15:0]                    out_underflow_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_RUN} state_t;

    localparam logic [7:0] BURST_LAST = 8'(INT_BURST_LEN - 1);
    localparam logic [7:0] SYNC_LAST  = 8'(INT_IQRST_CYCLES - 1);

    state_t                           state_q, state_d;
    logic                             g_q, g_d;
    logic [7:0]                       bc_q, bc_d;
    logic [7:0]                       sc_q, sc_d;
    logic [INT_AXIS_DATA_WIDTH-1:0]   data_q, data_d;
    logic [15:0]                      ucnt_q, ucnt_d;

    logic                             run;
    logic                             gnt_valid;
    logic                             oth_valid;
    logic [INT_AXIS_DATA_WIDTH-1:0]   gnt_data;

    assign run       = (state_q == ST_RUN);
    assign gnt_valid = g_q ? s1_axis_valid : s0_axis_valid;
    assign oth_valid = g_q ? s0_axis_valid : s1_axis_valid;
    assign gnt_data  = g_q ? s1_axis_data  : s0_axis_data;

    assign s0_axis_ready     = run & ~g_q & s0_axis_valid;
    assign s1_axis_ready     = run &  g_q & s1_axis_valid;
    assign m_axis_valid      = run;
    assign m_axis_data       = data_q;
    assign out_dac_rst       = ~run;
    assign out_grant         = g_q;
    assign out_underflow_cnt = ucnt_q;

    always_ff @(posedge aclk) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            g_q     <= 1'b0;
            bc_q    <= 8'd0;
            sc_q    <= 8'd0;
            data_q  <= '0;
            ucnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            bc_q    <= bc_d;
            sc_q    <= sc_d;
            data_q  <= data_d;
            ucnt_q  <= ucnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        bc_d    = bc_q;
        sc_d    = sc_q;
        data_d  = data_q;
        ucnt_d  = ucnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_enable) begin
                    state_d = ST_SYNC;
                    sc_d    = 8'd0;
                end
            end
            ST_SYNC: begin
                if (!in_enable) begin
                    state_d = ST_IDLE;
                    data_d  = '0;
                end else begin
                    sc_d = sc_q + 8'd1;
                    if (sc_q == SYNC_LAST) begin
                        state_d = ST_RUN;
                        g_d     = 1'b0;
                        bc_d    = 8'd0;
                    end
                end
            end
            ST_RUN: begin
                // A beat accepted while enable drops is intentionally discarded.
                if (!in_enable) begin
                    state_d = ST_IDLE;
                    data_d  = '0;
                end else if (gnt_valid) begin
                    data_d = gnt_data;
                    if (bc_q == BURST_LAST) begin
                        bc_d = 8'd0;
                        if (oth_valid) g_d = ~g_q;
                    end else begin
                        bc_d = bc_q + 8'd1;
                    end
                end else if (oth_valid) begin
                    g_d  = ~g_q;
                    bc_d = 8'd0;
                end else if (ucnt_q != 16'hFFFF) begin
                    ucnt_d = ucnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_stream_scheduler.sv
// Scoreboard bench: a transaction-level reference model predicts every cycle's
// outputs; a monitor on the falling edge pops and compares them.
module tb_dac_stream_scheduler;

    localparam int W     = 32;
    localparam int BURST = 16;
    localparam int IQ    = 4;

    logic          aclk = 1'b0;
    logic          in_rst, in_enable;
    logic          s0_axis_valid, s1_axis_valid;
    logic [W-1:0]  s0_axis_data, s1_axis_data;
    logic          s0_axis_ready, s1_axis_ready;
    logic          m_axis_valid;
    logic [W-1:0]  m_axis_data;
    logic          out_dac_rst, out_grant;
    logic [15:0]   out_underflow_cnt;

    dac_stream_scheduler #(
        .INT_AXIS_DATA_WIDTH(W),
        .INT_BURST_LEN(BURST),
        .INT_IQRST_CYCLES(IQ)
    ) dut (
        .aclk(aclk),
        .in_rst(in_rst),
        .in_enable(in_enable),
        .s0_axis_valid(s0_axis_valid),
        .s0_axis_data(s0_axis_data),
        .s0_axis_ready(s0_axis_ready),
        .s1_axis_valid(s1_axis_valid),
        .s1_axis_data(s1_axis_data),
        .s1_axis_ready(s1_axis_ready),
        .m_axis_valid(m_axis_valid),
        .m_axis_data(m_axis_data),
        .out_dac_rst(out_dac_rst),
        .out_grant(out_grant),
        .out_underflow_cnt(out_underflow_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [W-1:0] data;
        logic         valid;
        logic         dac_rst;
        logic         grant;
        logic [15:0]  ucnt;
        logic         r0;
        logic         r1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: how long enable has been continuously high decides the phase.
    int           age   = 0;
    int           mg    = 0;
    int           beats = 0;
    logic [W-1:0] mdata = '0;
    int           mu    = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("m_axis_data",  m_axis_data,               e.data);
            check("m_axis_valid", W'(m_axis_valid),          W'(e.valid));
            check("out_dac_rst",  W'(out_dac_rst),           W'(e.dac_rst));
            check("out_grant",    W'(out_grant),             W'(e.grant));
            check("underflow",    W'(out_underflow_cnt),     W'(e.ucnt));
            check("s0_ready",     W'(s0_axis_ready),         W'(e.r0));
            check("s1_ready",     W'(s1_axis_ready),         W'(e.r1));
        end
    end

    task automatic step(input logic rst, input logic en, input logic v0, input logic v1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1);
        exp_t e;
        logic run, gv, ov;
        @(posedge aclk);
        #1;
        in_rst = rst; in_enable = en;
        s0_axis_valid = v0; s1_axis_valid = v1;
        s0_axis_data = d0; s1_axis_data = d1;
        run       = (age > IQ);
        e.data    = mdata;
        e.valid   = run;
        e.dac_rst = !run;
        e.grant   = (mg != 0);
        e.ucnt    = 16'(mu);
        e.r0      = run && mg == 0 && v0;
        e.r1      = run && mg == 1 && v1;
        exp_q.push_back(e);
        if (rst) begin
            age = 0; mg = 0; beats = 0; mdata = '0; mu = 0;
        end else if (!en) begin
            if (age > 0) mdata = '0;
            age = 0;
        end else if (!run) begin
            age++;
            if (age == IQ + 1) begin mg = 0; beats = 0; end
        end else begin
            gv = (mg == 1) ? v1 : v0;
            ov = (mg == 1) ? v0 : v1;
            if (gv) begin
                mdata = (mg == 1) ? d1 : d0;
                beats++;
                if (beats == BURST) begin
                    beats = 0;
                    if (ov) mg = 1 - mg;
                end
            end else if (ov) begin
                mg = 1 - mg;
                beats = 0;
            end else if (mu < 16'hFFFF) begin
                mu++;
            end
        end
    endtask

    task automatic rnd_phase(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    initial begin
        in_rst = 1'b1; in_enable = 1'b0;
        s0_axis_valid = 1'b0; s1_axis_valid = 1'b0;
        s0_axis_data = '0; s1_axis_data = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_0000, '0);
        // start-up with s0 held valid
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'hA000_0000 + i, '0);
        // continuous contention, incrementing data
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0000 + i, 32'h2000_0000 + i);
        // both sources underflow
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom, $urandom);
        // empty-grant switches in both directions
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h3000_0000 + i, $urandom);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, 32'h4000_0000 + i);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h5000_0000 + i, $urandom);
        rnd_phase(300);
        // stop mid-burst, then restart
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h6000_0000 + i, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h6000_0007, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
        rnd_phase(40);
        // stop during SYNC
        step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
        step(1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
        step(1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
        step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
        rnd_phase(40);
        // reset in RUN with enable held: reset wins
        step(1'b1, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
        rnd_phase(40);
        // long underflow to saturate the counter
        for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom, $urandom);
        @(negedge aclk);
        check("underflow_saturated", W'(out_underflow_cnt), W'(16'hFFFF));
        rnd_phase(20);
        @(negedge aclk);
        @(negedge aclk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
